// File: rtl/load_store_unit.sv
// Load/store stage in front of the data memory: takes one LDR/STR at a time,
// forms the ARM-style effective address, drives the memory for one access,
// and hands the Rd/Rn writeback results to the register file.
module load_store_unit #(
    parameter int unsigned MEM_WORDS    = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    // request from execute
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [31:0]       req_base,
    input  logic [11:0]       req_offset,
    input  logic              req_up,
    input  logic              req_pre,
    input  logic              req_wback,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rn,
    input  logic [31:0]       req_store_data,
    // data memory
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_ldr_str_en,
    output logic              mem_load_en,
    output logic              mem_store_en,
    input  logic [31:0]       mem_read_data,
    // writeback to register file
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_rd_en,
    output logic [3:0]        wb_rd,
    output logic [31:0]       wb_rd_data,
    output logic              wb_rn_en,
    output logic [3:0]        wb_rn,
    output logic [31:0]       wb_rn_data,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  CNT_LAST   = 2'(READ_LATENCY - 1);

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       store_data_q, store_data_d;
    logic [3:0]        rd_q, rd_d;
    logic [3:0]        rn_q, rn_d;
    logic [31:0]       rn_data_q, rn_data_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              fault_q, fault_d;
    logic              rd_en_q, rd_en_d;
    logic              rn_en_q, rn_en_d;
    logic [1:0]        cnt_q, cnt_d;

    logic [31:0]       off_c;
    logic [31:0]       sum_c;
    logic [31:0]       ea_c;
    logic              fault_c;

    // Effective address and fault detection for the request on the input port
    always_comb begin
        off_c   = {20'd0, req_offset};
        sum_c   = req_up ? (req_base + off_c) : (req_base - off_c);
        ea_c    = req_pre ? sum_c : req_base;
        fault_c = (ea_c[1:0] != 2'b00) || (ea_c >= BYTE_LIMIT);
    end

    // Next-state logic and request capture
    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        rn_d         = rn_q;
        rn_data_d    = rn_data_q;
        rd_data_d    = rd_data_q;
        fault_d      = fault_q;
        rd_en_d      = rd_en_q;
        rn_en_d      = rn_en_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    load_d       = req_load;
                    addr_d       = ea_c[ADDR_W+1:2];
                    store_data_d = req_store_data;
                    rd_d         = req_rd;
                    rn_d         = req_rn;
                    rn_data_d    = sum_c;
                    fault_d      = fault_c;
                    rd_en_d      = req_load && !fault_c;
                    // a load into its own base register keeps the loaded value
                    rn_en_d      = (!req_pre || req_wback) && !fault_c &&
                                   !(req_load && (req_rd == req_rn));
                    cnt_d        = '0;
                    state_d      = fault_c ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = load_q ? WAIT : RESP;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    rd_data_d = mem_read_data;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            load_q       <= 1'b0;
            addr_q       <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
            rn_q         <= '0;
            rn_data_q    <= '0;
            rd_data_q    <= '0;
            fault_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rn_en_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
            rn_q         <= rn_d;
            rn_data_q    <= rn_data_d;
            rd_data_q    <= rd_data_d;
            fault_q      <= fault_d;
            rd_en_q      <= rd_en_d;
            rn_en_q      <= rn_en_d;
            cnt_q        <= cnt_d;
        end
    end

    // Memory and writeback outputs decoded from the current state
    always_comb begin
        req_ready      = (state_q == IDLE);
        mem_addr       = addr_q;
        mem_ldr_str_en = (state_q == ACCESS) || (state_q == WAIT);
        mem_load_en    = ((state_q == ACCESS) && load_q) || (state_q == WAIT);
        mem_store_en   = (state_q == ACCESS) && !load_q;
        mem_write_data = mem_store_en ? store_data_q : '0;
        wb_valid       = (state_q == RESP);
        wb_rd_en       = wb_valid && rd_en_q;
        wb_rn_en       = wb_valid && rn_en_q;
        fault          = wb_valid && fault_q;
        wb_rd          = wb_valid ? rd_q : '0;
        wb_rn          = wb_valid ? rn_q : '0;
        wb_rd_data     = wb_valid ? rd_data_q : '0;
        wb_rn_data     = wb_valid ? rn_data_q : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a behavioural
// memory on the bus and a separate reference memory for expectations.
module tb_load_store_unit;

    localparam int unsigned RL = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_up, req_pre, req_wback;
    logic [31:0] req_base, req_store_data;
    logic [11:0] req_offset;
    logic [3:0]  req_rd, req_rn;
    logic [3:0]  mem_addr;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_ldr_str_en, mem_load_en, mem_store_en;
    logic        wb_valid, wb_ready, wb_rd_en, wb_rn_en, fault;
    logic [3:0]  wb_rd, wb_rn;
    logic [31:0] wb_rd_data, wb_rn_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        seeded = 1'b0;

    load_store_unit #(
        .MEM_WORDS   (16),
        .ADDR_W      (4),
        .READ_LATENCY(RL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_load      (req_load),
        .req_base      (req_base),
        .req_offset    (req_offset),
        .req_up        (req_up),
        .req_pre       (req_pre),
        .req_wback     (req_wback),
        .req_rd        (req_rd),
        .req_rn        (req_rn),
        .req_store_data(req_store_data),
        .mem_addr      (mem_addr),
        .mem_write_data(mem_write_data),
        .mem_ldr_str_en(mem_ldr_str_en),
        .mem_load_en   (mem_load_en),
        .mem_store_en  (mem_store_en),
        .mem_read_data (mem_read_data),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_rd_en      (wb_rd_en),
        .wb_rd         (wb_rd),
        .wb_rd_data    (wb_rd_data),
        .wb_rn_en      (wb_rn_en),
        .wb_rn         (wb_rn),
        .wb_rn_data    (wb_rn_data),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    // Bus memory: seeded once during the first reset, one-cycle registered read
    always @(posedge clk) begin
        if (!rst && !seeded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 + 32'(i) * 32'h0001_0101;
            seeded        <= 1'b1;
            mem_read_data <= '0;
        end else begin
            if (mem_load_en)  mem_read_data  <= mem[mem_addr];
            if (mem_store_en) mem[mem_addr] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        else n_pass++;
    endtask

    // One full transaction against the reference model; hold = cycles of wb backpressure
    task automatic do_req(input logic ld, input logic [31:0] base, input logic [11:0] offs,
                          input logic up, input logic pre, input logic wback,
                          input logic [3:0] rd, input logic [3:0] rn,
                          input logic [31:0] sdata, input int unsigned hold);
        logic [31:0] off, sum, ea, e_rd_data, st_addr, st_data, ld_addr;
        logic        flt, e_rd_en, e_rn_en, seen;
        int unsigned n_st, n_ld, n_en, lat, exp_lat;
        logic [31:0] snap_rd_data, snap_rn_data, snap_ctl;

        off = 32'(offs);
        sum = up ? base + off : base - off;
        ea  = pre ? sum : base;
        flt = (ea % 4 != 0) || (ea >= 64);
        e_rd_en   = ld && !flt;
        e_rn_en   = (!pre || wback) && !flt && !(ld && rd == rn);
        e_rd_data = flt ? 32'd0 : ref_mem[ea / 4];
        if (!ld && !flt) ref_mem[ea / 4] = sdata;
        exp_lat = flt ? 0 : (ld ? RL + 1 : 1);

        check("idle_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_base = base; req_offset = offs;
        req_up = up; req_pre = pre; req_wback = wback; req_rd = rd; req_rn = rn;
        req_store_data = sdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        n_st = 0; n_ld = 0; n_en = 0; lat = 0; seen = 1'b0;
        st_addr = '0; st_data = '0; ld_addr = '0;
        for (int k = 0; k < 24 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) check("busy_ready", 32'(req_ready), 32'd0);
            if (mem_store_en) begin n_st++; st_addr = 32'(mem_addr); st_data = mem_write_data; end
            if (mem_load_en)  begin n_ld++; ld_addr = 32'(mem_addr); end
            if (mem_ldr_str_en) n_en++;
            if (wb_valid) begin seen = 1'b1; lat = k; end
        end
        check("wb_seen", 32'(seen), 32'd1);
        check("latency", lat, exp_lat);
        check("store_cycles", n_st, (!ld && !flt) ? 1 : 0);
        check("load_cycles", n_ld, (ld && !flt) ? RL + 1 : 0);
        check("en_cycles", n_en, flt ? 0 : (ld ? RL + 1 : 1));
        if (!ld && !flt) begin
            check("store_addr", st_addr, ea / 4);
            check("store_data", st_data, sdata);
        end
        if (ld && !flt) check("load_addr", ld_addr, ea / 4);
        check("fault", 32'(fault), 32'(flt));
        check("rd_en", 32'(wb_rd_en), 32'(e_rd_en));
        check("rn_en", 32'(wb_rn_en), 32'(e_rn_en));
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("wb_rn", 32'(wb_rn), 32'(rn));
        check("rn_data", wb_rn_data, sum);
        if (e_rd_en) check("rd_data", wb_rd_data, e_rd_data);

        snap_rd_data = wb_rd_data;
        snap_rn_data = wb_rn_data;
        snap_ctl     = {19'd0, fault, wb_rd_en, wb_rn_en, wb_valid, wb_rd, wb_rn};
        for (int h = 0; h < int'(hold); h++) begin
            req_valid = 1'b1;
            req_base  = $urandom;
            @(negedge clk);
            check("hold_ctl", {19'd0, fault, wb_rd_en, wb_rn_en, wb_valid, wb_rd, wb_rn}, snap_ctl);
            check("hold_rd_data", wb_rd_data, snap_rd_data);
            check("hold_rn_data", wb_rn_data, snap_rn_data);
            check("hold_ready", 32'(req_ready), 32'd0);
            check("hold_en", {29'd0, mem_ldr_str_en, mem_load_en, mem_store_en}, 32'd0);
        end
        req_valid = 1'b0;
        wb_ready  = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(wb_valid), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);
        wb_ready = 1'b0;
    endtask

    // Reset asserted while a store sits in ACCESS
    task automatic reset_mid_store();
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_base = 32'h20; req_offset = 12'd0;
        req_up = 1'b1; req_pre = 1'b1; req_wback = 1'b0; req_rd = 4'd1; req_rn = 4'd2;
        req_store_data = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_pre_store_en", 32'(mem_store_en), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_en_drop", {29'd0, mem_ldr_str_en, mem_load_en, mem_store_en}, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(req_ready), 32'd1);
        check("rst_rel_wb_valid", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] b;
        logic [11:0] o;
        logic [3:0]  rd, rn;

        rst = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_base = '0; req_offset = '0;
        req_up = 1'b0; req_pre = 1'b0; req_wback = 1'b0; req_rd = '0; req_rn = '0;
        req_store_data = '0; wb_ready = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 + 32'(i) * 32'h0001_0101;

        repeat (3) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_outs", {26'd0, wb_valid, wb_rd_en, wb_rn_en, fault, mem_load_en, mem_store_en}, 32'd0);
        check("reset_rn_data", wb_rn_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        reset_mid_store();

        // STR pre-index with writeback, then LDR post-index of the same word
        do_req(1'b0, 32'h10, 12'd4, 1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 32'hDEAD_BEEF, 0);
        do_req(1'b1, 32'h14, 12'd8, 1'b0, 1'b0, 1'b0, 4'd4, 4'd5, 32'h0, 0);
        // misaligned load and out-of-range store
        do_req(1'b1, 32'h12, 12'd0, 1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 32'h0, 0);
        do_req(1'b0, 32'h3C, 12'd4, 1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 32'h5555_AAAA, 1);
        // backpressure and load-into-base conflict
        do_req(1'b1, 32'h20, 12'd4, 1'b1, 1'b1, 1'b1, 4'd6, 4'd7, 32'h0, 5);
        do_req(1'b1, 32'h08, 12'd4, 1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 32'h0, 0);
        // last legal word and wrap below zero
        do_req(1'b0, 32'h3C, 12'd0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd8, 32'hCAFE_F00D, 0);
        do_req(1'b1, 32'h04, 12'd8, 1'b0, 1'b1, 1'b1, 4'd9, 4'd8, 32'h0, 0);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15)) * 4;
                1:       b = 32'($urandom_range(0, 70));
                2:       b = $urandom;
                default: b = 32'($urandom_range(0, 15)) * 4 + 64;
            endcase
            o  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 16) * 4);
            rd = 4'($urandom);
            rn = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom);
            do_req(1'($urandom), b, o, 1'($urandom), 1'($urandom), 1'($urandom),
                   rd, rn, $urandom, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
